// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and frame helpers for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam int TMR_W = 11;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_EXEC = 3'd5,
    S_READ = 3'd6,
    S_RESP = 3'd7
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

  // States in which a partial frame is open and the inter-byte timer runs.
  function automatic logic is_frame_state(input state_t s);
    return (s == S_CMD) || (s == S_ADDR) || (s == S_DATA) || (s == S_CHK);
  endfunction

  function automatic state_t next_frame_state(input state_t s);
    state_t n;
    case (s)
      S_CMD:   n = S_ADDR;
      S_ADDR:  n = S_DATA;
      S_DATA:  n = S_CHK;
      S_CHK:   n = S_EXEC;
      default: n = S_SYNC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-wide register bank bus between the command controller and the register bank.
interface uart_cmd_ctrl_if;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rd_data;

  modport master (
    output reg_wr_en,
    output reg_rd_en,
    output reg_addr,
    output reg_wdata,
    input  reg_rd_data
  );

  modport slave (
    input  reg_wr_en,
    input  reg_rd_en,
    input  reg_addr,
    input  reg_wdata,
    output reg_rd_data
  );
endinterface

// File: rtl/uart_byte_timer.sv
// Inter-byte gap counter: cleared on demand, counts while running, saturates at all-ones.
module uart_byte_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] MAX_CNT  = {TMR_W{1'b1}};

  logic [TMR_W-1:0] r_count;

  // gap counter with clear priority and saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_run && (r_count != MAX_CNT)) begin
      r_count <= r_count + {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_expire = i_run && (r_count == LAST_CNT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses A5/CMD/ADDR/DATA/CHK frames from the UART receiver, performs
// at most one register access per frame and returns ACK, NAK or the read data.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_pulse,
  input  logic            i_tx_busy,
  output logic            o_tx_start,
  output logic [7:0]      o_tx_data,
  output logic            o_err_pulse,
  output logic            o_ctrl_busy,
  uart_cmd_ctrl_if.master reg_bus
);

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_cmd;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_resp;
  logic [7:0] r_tx_data;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic       r_wr_en;
  logic       r_rd_en;
  logic       r_err;

  logic       w_run;
  logic       w_clear;
  logic       w_expire;
  logic       w_chk_ok;
  logic       w_frame_done;
  logic       w_timeout;
  logic       w_drop;
  logic       w_launch;
  logic       w_do_wr;
  logic       w_do_rd;
  logic       w_reject;
  logic       w_err_set;

  assign w_run   = is_frame_state(r_state);
  assign w_clear = i_rx_pulse | ~w_run;

  uart_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  assign w_chk_ok  = (i_rx_data == frame_chk(r_cmd, r_addr, r_data));
  assign w_do_wr   = w_frame_done & w_chk_ok & (r_cmd == CMD_WR);
  assign w_do_rd   = w_frame_done & w_chk_ok & (r_cmd == CMD_RD);
  assign w_reject  = w_frame_done & ~(w_do_wr | w_do_rd);
  assign w_err_set = w_reject | w_timeout | w_drop;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode; a byte arriving in the expiry cycle takes priority over the timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    w_drop       = 1'b0;
    w_launch     = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (i_rx_pulse && (i_rx_data == SYNC_BYTE)) begin
          w_state_nxt = S_CMD;
        end else begin
          w_state_nxt = S_SYNC;
        end
      end
      S_CMD, S_ADDR, S_DATA, S_CHK: begin
        if (i_rx_pulse) begin
          w_state_nxt  = next_frame_state(r_state);
          w_frame_done = (r_state == S_CHK);
        end else if (w_expire) begin
          w_state_nxt = S_SYNC;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_EXEC: begin
        w_drop = i_rx_pulse;
        if (r_rd_en) begin
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_READ: begin
        w_drop      = i_rx_pulse;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_drop = i_rx_pulse;
        if (!i_tx_busy) begin
          w_launch    = 1'b1;
          w_state_nxt = S_SYNC;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_SYNC;
      end
    endcase
  end

  // frame latches, register-bus strobes, response byte and transmit holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= 8'h00;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_resp      <= 8'h00;
      r_tx_data   <= 8'h00;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_en <= w_do_wr;
      r_rd_en <= w_do_rd;
      r_err   <= w_err_set;
      if (i_rx_pulse) begin
        case (r_state)
          S_CMD:   r_cmd  <= i_rx_data;
          S_ADDR:  r_addr <= i_rx_data;
          S_DATA:  r_data <= i_rx_data;
          default: ;
        endcase
      end
      // bus address/data only move on an accepted access so they hold between accesses
      if (w_do_wr || w_do_rd) begin
        r_reg_addr <= r_addr;
      end
      if (w_do_wr) begin
        r_reg_wdata <= r_data;
      end
      if (w_do_wr) begin
        r_resp <= RSP_ACK;
      end else if (w_reject) begin
        r_resp <= RSP_NAK;
      end else if (r_state == S_READ) begin
        r_resp <= reg_bus.reg_rd_data;
      end
      if (w_launch) begin
        r_tx_data <= r_resp;
      end
    end
  end

  assign o_tx_start  = w_launch;
  assign o_tx_data   = w_launch ? r_resp : r_tx_data;
  assign o_err_pulse = r_err;
  assign o_ctrl_busy = (r_state != S_SYNC);

  assign reg_bus.reg_wr_en = r_wr_en;
  assign reg_bus.reg_rd_en = r_rd_en;
  assign reg_bus.reg_addr  = r_reg_addr;
  assign reg_bus.reg_wdata = r_reg_wdata;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_cmd_ctrl;

  localparam int TOUT = 2000;
  localparam int TXB  = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_pulse;
  logic       tx_force;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       err_pulse;
  logic       ctrl_busy;
  logic [7:0] rd_q;
  int         tx_cnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.TIMEOUT_CYC(TOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (rx_data),
    .i_rx_pulse  (rx_pulse),
    .i_tx_busy   (tx_busy),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .o_err_pulse (err_pulse),
    .o_ctrl_busy (ctrl_busy),
    .reg_bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [7:0] a);
    return a ^ 8'h5E;
  endfunction

  // register bank: read data valid the cycle after reg_rd_en
  always @(posedge clk) rd_q <= bus.reg_rd_en ? rom(bus.reg_addr) : 8'h00;
  assign bus.reg_rd_data = rd_q;

  // transmitter: busy from the cycle after tx_start for one byte time
  always @(posedge clk) begin
    if (tx_start) tx_cnt <= TXB;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = tx_force | (tx_cnt != 0);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // frame-level reference model
  bit         m_active = 1'b0;
  bit         m_post = 1'b0;
  int         m_last = 0;
  int         m_exec_t = -1;
  int         m_ready = 0;
  int         m_kind = 0;
  logic [7:0] m_resp = 8'h00;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] fb[$];
  bit         err_due[int];

  // observation records for the directed checks
  int         n_wr, n_rd, n_start, n_err, n_nak;
  int         wr_t, rd_t, start_t, err_t;
  logic [7:0] wr_addr, wr_data, rd_addr, last_txd;

  always @(negedge clk) begin
    bit         e_start, e_wr, e_rd, e_err;
    logic [7:0] e_txd;
    e_start = m_post && (cyc >= m_ready) && !tx_busy;
    e_wr    = (cyc == m_exec_t) && (m_kind == 1);
    e_rd    = (cyc == m_exec_t) && (m_kind == 2);
    e_err   = err_due.exists(cyc);
    e_txd   = e_start ? m_resp : m_tx;

    chk("reg_wr_en", int'(bus.reg_wr_en), int'(e_wr));
    chk("reg_rd_en", int'(bus.reg_rd_en), int'(e_rd));
    chk("reg_addr", int'(bus.reg_addr), int'(m_addr));
    chk("reg_wdata", int'(bus.reg_wdata), int'(m_wdata));
    chk("tx_start", int'(tx_start), int'(e_start));
    chk("tx_data", int'(tx_data), int'(e_txd));
    chk("err_pulse", int'(err_pulse), int'(e_err));
    chk("ctrl_busy", int'(ctrl_busy), int'(m_active));

    if (bus.reg_wr_en) begin n_wr++; wr_t = cyc; wr_addr = bus.reg_addr; wr_data = bus.reg_wdata; end
    if (bus.reg_rd_en) begin n_rd++; rd_t = cyc; rd_addr = bus.reg_addr; end
    if (err_pulse) begin n_err++; err_t = cyc; end
    if (tx_start) begin
      n_start++; start_t = cyc; last_txd = tx_data;
      if (tx_data == 8'h15) n_nak++;
    end

    if (rst) begin
      m_active = 1'b0; m_post = 1'b0; m_exec_t = -1; m_kind = 0;
      m_resp = 8'h00; m_tx = 8'h00; m_addr = 8'h00; m_wdata = 8'h00;
      fb.delete(); err_due.delete();
    end else begin
      if (e_err) err_due.delete(cyc);
      if (m_post) begin
        if (rx_pulse) err_due[cyc + 1] = 1'b1;
        if (e_start) begin m_post = 1'b0; m_active = 1'b0; m_tx = m_resp; end
      end else if (m_active) begin
        if (rx_pulse) begin
          m_last = cyc;
          if (fb.size() < 3) begin
            fb.push_back(rx_data);
          end else begin
            m_exec_t = cyc + 1; m_ready = cyc + 2; m_post = 1'b1; m_kind = 0;
            if (rx_data == (fb[0] ^ fb[1] ^ fb[2]) && fb[0] == 8'h01) begin
              m_kind = 1; m_addr = fb[1]; m_wdata = fb[2]; m_resp = 8'h06;
            end else if (rx_data == (fb[0] ^ fb[1] ^ fb[2]) && fb[0] == 8'h02) begin
              m_kind = 2; m_addr = fb[1]; m_resp = rom(fb[1]); m_ready = cyc + 3;
            end else begin
              m_resp = 8'h15; err_due[cyc + 1] = 1'b1;
            end
            fb.delete();
          end
        end else if (cyc - m_last == TOUT) begin
          err_due[cyc + 1] = 1'b1; m_active = 1'b0; fb.delete();
        end
      end else if (rx_pulse && rx_data == 8'hA5) begin
        m_active = 1'b1; m_last = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    t = cyc; rx_data = b; rx_pulse = 1'b1;
    tick(1);
    rx_pulse = 1'b0; rx_data = 8'h00;
    tick(gap);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    int t;
    send_byte(8'hA5, 2, t); send_byte(c, 2, t); send_byte(a, 2, t);
    send_byte(d, 2, t); send_byte(k, 2, t);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((ctrl_busy || tx_busy) && n < 5000) begin tick(1); n++; end
    chk(name, int'(ctrl_busy || tx_busy), 0);
  endtask

  task automatic clear_obs();
    n_wr = 0; n_rd = 0; n_start = 0; n_err = 0; n_nak = 0;
    wr_t = -1; rd_t = -1; start_t = -1; err_t = -1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_err"}, int'(err_pulse), 0);
    chk({tag, "_busy"}, int'(ctrl_busy), 0);
    chk({tag, "_wr_en"}, int'(bus.reg_wr_en), 0);
    chk({tag, "_rd_en"}, int'(bus.reg_rd_en), 0);
    chk({tag, "_addr"}, int'(bus.reg_addr), 0);
    chk({tag, "_wdata"}, int'(bus.reg_wdata), 0);
  endtask

  initial begin
    int t1;
    int f;
    rst = 1'b1; rx_pulse = 1'b0; rx_data = 8'h00; tx_force = 1'b0;
    clear_obs();
    tick(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // write frame
    clear_obs();
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    wait_idle("wr_idle");
    chk("wr_count", n_wr, 1);
    chk("wr_addr", int'(wr_addr), 'h10);
    chk("wr_data", int'(wr_data), 'h3C);
    chk("wr_starts", n_start, 1);
    chk("wr_txd", int'(last_txd), 'h06);
    chk("wr_errs", n_err, 0);
    chk("wr_to_start", start_t - wr_t, 1);

    // read frame, register returns 0x7E
    clear_obs();
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);
    wait_idle("rd_idle");
    chk("rd_count", n_rd, 1);
    chk("rd_addr", int'(rd_addr), 'h20);
    chk("rd_txd", int'(last_txd), 'h7E);
    chk("rd_to_start", start_t - rd_t, 2);
    chk("rd_no_wr", n_wr, 0);

    // bad checksum then unknown command
    clear_obs();
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
    wait_idle("nak1_idle");
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    wait_idle("nak2_idle");
    chk("nak_wr", n_wr, 0);
    chk("nak_rd", n_rd, 0);
    chk("nak_count", n_nak, 2);
    chk("nak_errs", n_err, 2);

    // garbage ignored, then timeout after A5 01
    clear_obs();
    send_byte(8'h00, 2, t1); send_byte(8'hFF, 2, t1);
    chk("garbage_errs", n_err, 0);
    send_byte(8'hA5, 2, t1); send_byte(8'h01, 0, t1);
    tick(TOUT + 2);
    chk("tout_errs", n_err, 1);
    chk("tout_err_cycle", err_t, t1 + TOUT + 1);
    chk("tout_busy", int'(ctrl_busy), 0);
    clear_obs();
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    wait_idle("post_tout_idle");
    chk("post_tout_wr", n_wr, 1);

    // byte landing exactly in the expiry cycle is accepted
    clear_obs();
    send_byte(8'hA5, 2, t1); send_byte(8'h01, TOUT - 1, t1);
    send_byte(8'h44, 2, t1); send_byte(8'h55, 2, t1); send_byte(8'h10, 2, t1);
    wait_idle("edge_idle");
    chk("edge_errs", n_err, 0);
    chk("edge_wr", n_wr, 1);
    chk("edge_addr", int'(wr_addr), 'h44);

    // transmitter held busy for 1000 cycles, stray byte during the wait
    clear_obs();
    tx_force = 1'b1;
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    tick(100);
    send_byte(8'h55, 2, t1);
    tick(880);
    chk("hold_no_start", n_start, 0);
    chk("hold_still_busy", int'(ctrl_busy), 1);
    tx_force = 1'b0; f = cyc;
    tick(2);
    chk("hold_start_cycle", start_t, f);
    chk("hold_starts", n_start, 1);
    chk("hold_txd", int'(last_txd), 'h06);
    chk("hold_errs", n_err, 1);
    chk("hold_wr", n_wr, 1);
    wait_idle("hold_idle");

    // reset in the middle of a frame
    clear_obs();
    send_byte(8'hA5, 2, t1); send_byte(8'h01, 2, t1); send_byte(8'h10, 2, t1);
    rst = 1'b1;
    tick(2);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick(2);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    wait_idle("after_rst_idle");
    chk("after_rst_wr", n_wr, 1);
    chk("after_rst_addr", int'(wr_addr), 'h10);
    chk("after_rst_txd", int'(last_txd), 'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller that sits between the UART receiver, the UART transmitter and a byte-wide register bank. It parses 5-byte command frames from the receiver's byte/pulse stream, validates them, and issues single-cycle register writes or reads. It then sequences the transmitter to return an ACK byte, a NAK byte or the read data. All timing is in `clk` cycles. One UART bit is 50 cycles, so one byte is 500 cycles.

## Interface
- `TIMEOUT_CYC`, default 2000: maximum gap between consecutive bytes of a frame (4 byte times) before the partial frame is discarded.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte; valid only when `rx_pulse`=1.
- `rx_pulse` in 1: one-cycle strobe per received byte.
- `tx_busy` in 1: transmitter busy; rises the cycle after `tx_start` and falls when the stop bit ends.
- `tx_start` out 1: one-cycle request to transmit `tx_data`.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until the next `tx_start`.
- `reg_wr_en` out 1: one-cycle register write strobe.
- `reg_rd_en` out 1: one-cycle register read strobe.
- `reg_addr` out 8: register address.
- `reg_wdata` out 8: write data.
- `reg_rd_data` in 8: read data, valid exactly 1 cycle after `reg_rd_en`.
- `err_pulse` out 1: one-cycle strobe on a rejected frame, timeout or dropped byte.
- `ctrl_busy` out 1: high in every state except S_SYNC.

## Operation
- Frame format: `0xA5` (sync), CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
- Supported commands: CMD `0x01` = write, CMD `0x02` = read. For a read, DATA is a don't-care but is still included in CHK.
- State transitions (each advance happens on a cycle with `rx_pulse`=1):
  - S_SYNC: a byte equal to `0xA5` moves to S_CMD. Any other byte is silently ignored, with no `err_pulse`.
  - S_CMD: latch the byte, go to S_ADDR.
  - S_ADDR: latch the byte, go to S_DATA.
  - S_DATA: latch the byte, go to S_CHK.
  - S_CHK: compare the byte with the computed CHK, go to S_EXEC.
- S_EXEC behaviour:
  - Checksum OK and CMD=`0x01`: pulse `reg_wr_en` with `reg_addr`/`reg_wdata` driven; response byte = `0x06`; go to S_RESP.
  - Checksum OK and CMD=`0x02`: pulse `reg_rd_en`; go to S_READ.
  - Checksum bad, or CMD is any other value: no register access; pulse `err_pulse`; response byte = `0x15`; go to S_RESP.
- S_READ: capture `reg_rd_data` as the response byte; go to S_RESP.
- S_RESP:
  - Wait until `tx_busy`=0, then load `tx_data`, pulse `tx_start` and go to S_SYNC.
  - `tx_busy` is not sampled in the cycle immediately after `tx_start`.
- Timeout:
  - The inter-byte counter runs only in S_CMD through S_CHK and reloads to 0 on every `rx_pulse`.
  - When it reaches `TIMEOUT_CYC`-1: pulse `err_pulse`, discard the frame and go to S_SYNC.
  - If `rx_pulse` arrives in the expiry cycle, the byte wins: the frame is accepted and the counter reloads.
- An `rx_pulse` in S_EXEC, S_READ or S_RESP drops the byte and pulses `err_pulse`.
- Reset at any point returns to S_SYNC and discards any partial frame.

## Timing
- Reset values: every output is 0. The internal CMD/ADDR/DATA latches, response byte and counter are also 0.
- Write: CHK `rx_pulse` at cycle N, S_EXEC at N+1, `reg_wr_en` high during N+1. With `tx_busy`=0, `tx_start` is high at N+2.
- Read: `reg_rd_en` high during N+1, `reg_rd_data` sampled at N+2, `tx_start` at N+3 if the transmitter is idle.
- `reg_addr` and `reg_wdata` hold their last value between accesses.
- At most one register access per frame.
- The checksum is an 8-bit XOR with no carry. The timeout counter is 11 bits wide and saturates without wrapping.

## Structure
- Package `uart_cmd_pkg` holds:
  - constants `SYNC_BYTE`=`0xA5`, `CMD_WR`=`0x01`, `CMD_RD`=`0x02`, `RSP_ACK`=`0x06`, `RSP_NAK`=`0x15`;
  - the 3-bit state encoding S_SYNC, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_READ, S_RESP.
- One sub-module, `uart_byte_timer`: the inter-byte timeout counter, with inputs `clear`/`run` and output `expire`.

## Test plan
- Write frame A5 01 10 3C 2D -> exactly one `reg_wr_en` with `reg_addr`=`0x10`, `reg_wdata`=`0x3C`; `tx_start` with `tx_data`=`0x06`; `err_pulse` never asserted.
- Read frame A5 02 20 00 22 with the register returning `0x7E` -> one `reg_rd_en` with `reg_addr`=`0x20`; `tx_data`=`0x7E` at `tx_start`, which occurs 2 cycles after `reg_rd_en`.
- Bad checksum A5 01 10 3C 00, then unknown command A5 07 00 00 07 -> no `reg_wr_en`/`reg_rd_en`; `tx_data`=`0x15` twice; `err_pulse` twice.
- A5 01, then 2000 idle cycles -> `err_pulse` at expiry and `ctrl_busy` falls. A following valid write frame still completes. Garbage bytes 00 FF before a sync byte are ignored with no `err_pulse`.
- `tx_busy` held high for 1000 cycles after a valid frame -> `tx_start` only in the cycle after `tx_busy` falls. A byte received during the wait -> `err_pulse` and no state change.
- `rst` asserted after A5 01 10 -> all outputs 0. The next complete frame A5 01 10 3C 2D executes normally.
